// File: rtl/mirfak_clint.sv
// Single-hart machine-level CLINT (msip, mtime, mtimecmp) behind a Wishbone B4 classic slave.
// Optional mtime prescaler is compiled in with `define MIRFAK_CLINT_PRESCALER_EN (ratio TICK_DIV).
module mirfak_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

    logic [15:0] offset;
    logic        hit, accept, mapped, wr_en;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic        msip;
    logic [63:0] mtime, mtimecmp;
    logic [31:0] rdata;
    logic        tick;
    logic        unused_ok;

    // Handshake: a request is taken when cyc&stb are high and no response is
    // being presented; exactly one of ack/err follows on the next edge for a
    // single cycle, so a master holding stb gets one transfer every 2 cycles.
    assign accept      = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o;
    assign hit         = (wbs_addr_i[31:16] == BASE_ADDR[31:16]);
    assign offset      = {wbs_addr_i[15:2], 2'b00};
    assign sel_msip    = hit && (offset == OFF_MSIP);
    assign sel_cmp_lo  = hit && (offset == OFF_CMP_LO);
    assign sel_cmp_hi  = hit && (offset == OFF_CMP_HI);
    assign sel_time_lo = hit && (offset == OFF_TIME_LO);
    assign sel_time_hi = hit && (offset == OFF_TIME_HI);
    assign mapped      = sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi;
    assign wr_en       = accept && mapped && wbs_we_i;
    assign unused_ok   = ^wbs_addr_i[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rdata = 32'h0;
        if (sel_msip)    rdata = {31'h0, msip};
        if (sel_cmp_lo)  rdata = mtimecmp[31:0];
        if (sel_cmp_hi)  rdata = mtimecmp[63:32];
        if (sel_time_lo) rdata = mtime[31:0];
        if (sel_time_hi) rdata = mtime[63:32];
    end

`ifdef MIRFAK_CLINT_PRESCALER_EN
    logic [15:0] presc;

    assign tick = (presc == 16'(TICK_DIV - 1));

    // A software write to mtime restarts the prescale period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc <= 16'h0;
        end else if (wr_en && (sel_time_lo || sel_time_hi)) begin
            presc <= 16'h0;
        end else if (tick) begin
            presc <= 16'h0;
        end else begin
            presc <= presc + 16'h1;
        end
    end
`else
    logic unused_div;

    assign tick       = 1'b1;
    assign unused_div = (TICK_DIV == 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= accept && mapped;
            wbs_err_o <= accept && !mapped;
            wbs_dat_o <= (accept && mapped) ? rdata : 32'h0;
        end
    end

    // An mtime write suppresses that cycle's increment; the other word holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msip     <= 1'b0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime    <= 64'h0;
        end else begin
            if (wr_en && sel_msip && wbs_sel_i[0]) msip <= wbs_dat_i[0];
            if (wr_en && sel_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
            if (wr_en && sel_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
            if (wr_en && sel_time_lo) begin
                mtime[31:0] <= merge_bytes(mtime[31:0], wbs_dat_i, wbs_sel_i);
            end else if (wr_en && sel_time_hi) begin
                mtime[63:32] <= merge_bytes(mtime[63:32], wbs_dat_i, wbs_sel_i);
            end else if (tick) begin
                mtime <= mtime + 64'h1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xint_mtip_o <= 1'b0;
        end else begin
            xint_mtip_o <= (mtime >= mtimecmp);
        end
    end

    assign xint_msip_o = msip;

endmodule

// File: tb/tb_mirfak_clint.sv
// Bench for mirfak_clint: directed plan items plus random bus traffic, checked
// against a time-based register model through an expected-response queue.
module tb_mirfak_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef MIRFAK_CLINT_PRESCALER_EN
    localparam int unsigned TDIV = 4;
`else
    localparam int unsigned TDIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbs_addr = 32'h0;
    logic [31:0] wbs_dat_w = 32'h0;
    logic [3:0]  wbs_sel = 4'h0;
    logic        wbs_cyc = 1'b0;
    logic        wbs_stb = 1'b0;
    logic        wbs_we = 1'b0;
    logic [31:0] wbs_dat_r;
    logic        wbs_ack, wbs_err, mtip, msip;

    mirfak_clint #(.BASE_ADDR(BASE), .TICK_DIV(TDIV)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wbs_addr_i(wbs_addr), .wbs_dat_i(wbs_dat_w), .wbs_sel_i(wbs_sel),
        .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
        .wbs_dat_o(wbs_dat_r), .wbs_ack_o(wbs_ack), .wbs_err_o(wbs_err),
        .xint_mtip_o(mtip), .xint_msip_o(msip)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int unsigned cyc_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt <= 0;
        else        cyc_cnt <= cyc_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // mtime is modelled as anchor value plus elapsed ticks since the anchor cycle.
    logic [63:0] m_anchor_val;
    int unsigned m_anchor_n;
    logic [63:0] m_cmp;
    logic        m_msip;

    function automatic logic [63:0] mtime_at(input int unsigned n);
        return m_anchor_val + 64'((n - m_anchor_n) / TDIV);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    // entry = {check_data, is_err, data[31:0], due_cycle[31:0]}
    logic [65:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    logic ge_prev;
    logic ge_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [65:0] e;
            if (wbs_ack || wbs_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {62'h0, wbs_ack, wbs_err}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", {62'h0, wbs_ack, wbs_err}, {62'h0, !e[64], e[64]});
                    check("resp_cycle", 64'(cyc_cnt), 64'(e[31:0]));
                    if (e[65]) check("resp_data", 64'(wbs_dat_r), 64'(e[63:32]));
                end
            end else if (exp_q.size() > 0 && exp_q[0][31:0] < cyc_cnt) begin
                e = exp_q.pop_front();
                check("resp_timeout", 64'(cyc_cnt), 64'(e[31:0]));
            end
            if (ge_valid) check("mtip", 64'(mtip), 64'(ge_prev));
            check("msip", 64'(msip), 64'(m_msip));
            ge_prev  = (mtime_at(cyc_cnt) >= m_cmp);
            ge_valid = 1'b1;
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 one idle cycle after the response.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel);
        int unsigned n;
        logic [15:0] off;
        logic        mapped;
        logic [31:0] rd;
        logic [63:0] v;
        n      = cyc_cnt;
        off    = {addr[15:2], 2'b00};
        mapped = (addr[31:16] == BASE[31:16]) &&
                 (off == 16'h0000 || off == 16'h4000 || off == 16'h4004 ||
                  off == 16'hBFF8 || off == 16'hBFFC);
        v = mtime_at(n);
        case (off)
            16'h0000: rd = {31'h0, m_msip};
            16'h4000: rd = m_cmp[31:0];
            16'h4004: rd = m_cmp[63:32];
            16'hBFF8: rd = v[31:0];
            16'hBFFC: rd = v[63:32];
            default:  rd = 32'h0;
        endcase
        if (!mapped) rd = 32'h0;
        exp_q.push_back({(!we || !mapped), !mapped, rd, n + 1});
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        wbs_addr = addr; wbs_dat_w = data; wbs_sel = sel;
        @(posedge clk); #1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        if (we && mapped) begin
            case (off)
                16'h0000: if (sel[0]) m_msip = data[0];
                16'h4000: m_cmp[31:0]  = lane_merge(m_cmp[31:0], data, sel);
                16'h4004: m_cmp[63:32] = lane_merge(m_cmp[63:32], data, sel);
                16'hBFF8: begin
                    v[31:0] = lane_merge(v[31:0], data, sel);
                    m_anchor_val = v; m_anchor_n = n + 1;
                end
                16'hBFFC: begin
                    v[63:32] = lane_merge(v[63:32], data, sel);
                    m_anchor_val = v; m_anchor_n = n + 1;
                end
                default: ;
            endcase
        end
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_anchor_val = 64'h0; m_anchor_n = 0;
        m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0;
        exp_q.delete();
        ge_prev = 1'b0; ge_valid = 1'b1;
    endtask

    task automatic release_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] off_tab [7];
    initial begin
        int waited;
        logic [63:0] t;
        off_tab[0] = 16'h0000; off_tab[1] = 16'h4000; off_tab[2] = 16'h4004;
        off_tab[3] = 16'hBFF8; off_tab[4] = 16'hBFFC; off_tab[5] = 16'h0008;
        off_tab[6] = 16'h4008;
        model_reset();
        #1;
        check("rst_ack", 64'(wbs_ack), 64'h0);
        check("rst_err", 64'(wbs_err), 64'h0);
        check("rst_dat", 64'(wbs_dat_r), 64'h0);
        check("rst_mtip", 64'(mtip), 64'h0);
        check("rst_msip", 64'(msip), 64'h0);
        #30;
        release_reset();

        // idle then mtime read
        idle(10);
        xfer(1'b0, BASE + 32'hBFF8, 32'h0, 4'hF);
        xfer(1'b0, BASE + 32'hBFFC, 32'h0, 4'hF);

        // msip set / clear / read
        xfer(1'b1, BASE + 32'h0000, 32'h1, 4'b0001);
        xfer(1'b1, BASE + 32'h0000, 32'h0, 4'b0001);
        xfer(1'b0, BASE + 32'h0000, 32'h0, 4'hF);

        // carry from mtime lo into hi
        xfer(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
        xfer(1'b1, BASE + 32'hBFFC, 32'h0000_0000, 4'hF);
        idle(3);
        xfer(1'b0, BASE + 32'hBFFC, 32'h0, 4'hF);
        xfer(1'b0, BASE + 32'hBFF8, 32'h0, 4'hF);

        // mtimecmp crossing and release
        xfer(1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b1, BASE + 32'h4004, 32'h0, 4'hF);
        t = mtime_at(cyc_cnt) + 64'd20;
        xfer(1'b1, BASE + 32'h4000, t[31:0], 4'hF);
        waited = 0;
        while (!mtip && waited < 80) begin
            @(posedge clk); #1;
            waited++;
        end
        check("mtip_rise_seen", 64'(mtip), 64'h1);
        xfer(1'b1, BASE + 32'h4004, 32'hFFFF_FFFF, 4'hF);
        check("mtip_fall", 64'(mtip), 64'h0);

        // error responses and partial-lane write
        xfer(1'b0, BASE + 32'h0008, 32'h0, 4'hF);
        xfer(1'b0, 32'h0300_0000, 32'h0, 4'hF);
        xfer(1'b1, 32'h0201_4000, 32'hDEAD_BEEF, 4'hF);
        xfer(1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b1, BASE + 32'h4000, 32'h1234_5678, 4'b0011);
        xfer(1'b0, BASE + 32'h4000, 32'h0, 4'hF);
        xfer(1'b1, BASE + 32'h0000, 32'h1, 4'b0000);
        xfer(1'b0, BASE + 32'h0003, 32'h0, 4'hF);

        // prescaled (or plain) counting after an mtime write of 0
        xfer(1'b1, BASE + 32'hBFF8, 32'h0, 4'hF);
        idle(38);
        xfer(1'b0, BASE + 32'hBFF8, 32'h0, 4'hF);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = {BASE[31:16], off_tab[$urandom_range(0, 6)]} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a[31:16] = 16'($urandom);
            s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            xfer($urandom_range(0, 2) == 0, a, $urandom, s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        // reset in the middle of a transfer
        xfer(1'b1, BASE + 32'h0000, 32'h1, 4'h1);
        xfer(1'b1, BASE + 32'h4004, 32'h0, 4'hF);
        xfer(1'b1, BASE + 32'h4000, 32'h0, 4'hF);
        check("pre_rst_mtip", 64'(mtip), 64'h1);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0;
        wbs_addr = BASE + 32'hBFF8; wbs_sel = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", 64'(wbs_ack), 64'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        check("mid_rst_ack", 64'(wbs_ack), 64'h0);
        check("mid_rst_dat", 64'(wbs_dat_r), 64'h0);
        check("mid_rst_mtip", 64'(mtip), 64'h0);
        check("mid_rst_msip", 64'(msip), 64'h0);
        #20;
        release_reset();
        xfer(1'b0, BASE + 32'h4000, 32'h0, 4'hF);
        xfer(1'b0, BASE + 32'h4004, 32'h0, 4'hF);
        xfer(1'b0, BASE + 32'hBFF8, 32'h0, 4'hF);
        xfer(1'b0, BASE + 32'h0000, 32'h0, 4'hF);
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
